// File: rtl/acumulador_promediador.sv
// acumulador_promediador: sums 2**LOG2_N signed 64-bit samples and emits their average once per frame.
// Latency: data_valid_out pulses on the clock edge after the last sample of a frame; 1 sample/cycle, no gap between frames.
// Backpressure: none; enable=0 freezes all state and suppresses the output pulse, clear restarts the frame.
// Optional build macro ACUMULADOR_REDONDEO_EN: round half toward +inf instead of flooring the average.
module acumulador_promediador #(
    parameter int LOG2_N = 10,
    parameter int ACC_W  = 80
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              enable,
    input  logic              clear,
    input  logic [63:0]       data_in,
    input  logic              data_valid,
    output logic [63:0]       data_out,
    output logic              data_valid_out,
    output logic [LOG2_N-1:0] sample_count,
    output logic [15:0]       frame_count
);

    // Reject configurations where the frame sum could overflow or the counter is out of range.
    if (LOG2_N < 1 || LOG2_N > 16) begin : g_bad_log2_n
        $error("acumulador_promediador: LOG2_N must be in 1..16");
    end
    if (ACC_W < 64 + LOG2_N) begin : g_bad_acc_w
        $error("acumulador_promediador: ACC_W must be >= 64+LOG2_N");
    end

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        ACUM = 1'b1
    } state_t;

    state_t state;
    state_t state_nxt;

    logic signed [ACC_W-1:0] acc;
    logic signed [ACC_W-1:0] sample_ext;
    logic signed [ACC_W-1:0] sum;
    logic [63:0]             avg;

    logic accept;      // sample taken into the frame this cycle
    logic restart;     // frame restart request honoured this cycle
    logic last;        // the next accepted sample closes the frame
    logic frame_end;   // closing sample accepted: dump the average

    assign accept    = enable & data_valid & ~clear;
    assign restart   = enable & clear;
    assign last      = &sample_count;
    assign frame_end = accept & last;

    // The full frame sum is formed combinationally so the closing sample is averaged in the same cycle.
    assign sample_ext = {{(ACC_W-64){data_in[63]}}, data_in};
    assign sum        = acc + sample_ext;

`ifdef ACUMULADOR_REDONDEO_EN
    // One extra bit keeps the half-LSB bias from wrapping a maximum-magnitude positive sum.
    localparam logic signed [ACC_W:0] HALF = (ACC_W+1)'(1) << (LOG2_N-1);

    logic signed [ACC_W:0] sum_rnd;
    logic signed [ACC_W:0] avg_full;
    logic [ACC_W-64:0]     avg_unused;

    assign sum_rnd    = $signed({sum[ACC_W-1], sum}) + HALF;
    assign avg_full   = sum_rnd >>> LOG2_N;
    assign avg        = avg_full[63:0];
    assign avg_unused = avg_full[ACC_W:64];
`else
    // Arithmetic shift floors toward -inf; the width rule keeps the quotient inside 64 bits.
    logic signed [ACC_W-1:0] avg_full;
    logic [ACC_W-65:0]       avg_unused;

    assign avg_full   = sum >>> LOG2_N;
    assign avg        = avg_full[63:0];
    assign avg_unused = avg_full[ACC_W-1:64];
`endif

    // State register: IDLE between frames, ACUM while a partial sum is held.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic; a restart always wins over a coincident sample.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (accept) begin
                    state_nxt = ACUM;
                end
            end
            ACUM: begin
                if (restart || frame_end) begin
                    state_nxt = IDLE;
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // Accumulator and sample counter: add, dump-and-zero at frame end, or zero on restart.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            acc          <= '0;
            sample_count <= '0;
        end else if (restart) begin
            acc          <= '0;
            sample_count <= '0;
        end else if (frame_end) begin
            acc          <= '0;
            sample_count <= '0;
        end else if (accept) begin
            acc          <= sum;
            sample_count <= sample_count + 1'b1;
        end
    end

    // Output sample and frame counter update only when a frame closes; they survive clear and enable=0.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            data_out    <= '0;
            frame_count <= '0;
        end else if (frame_end) begin
            data_out    <= avg;
            frame_count <= frame_count + 16'd1;
        end
    end

    // Valid pulse lasts exactly one cycle; it can only rise when enable is high.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            data_valid_out <= 1'b0;
        end else begin
            data_valid_out <= frame_end;
        end
    end

endmodule

// File: tb/tb_acumulador_promediador.sv
// Bench for acumulador_promediador with LOG2_N=2 (4-sample frames).
// Stimulus pushes the expected average, frame number and output cycle into a queue.
// A negedge monitor pops and compares on every data_valid_out pulse.
module tb_acumulador_promediador;

    localparam int LOG2_N = 2;
    localparam int ACC_W  = 80;

    logic              clock;
    logic              reset;
    logic              enable;
    logic              clear;
    logic [63:0]       data_in;
    logic              data_valid;
    logic [63:0]       data_out;
    logic              data_valid_out;
    logic [LOG2_N-1:0] sample_count;
    logic [15:0]       frame_count;

    acumulador_promediador #(
        .LOG2_N(LOG2_N),
        .ACC_W (ACC_W)
    ) dut (
        .clock         (clock),
        .reset         (reset),
        .enable        (enable),
        .clear         (clear),
        .data_in       (data_in),
        .data_valid    (data_valid),
        .data_out      (data_out),
        .data_valid_out(data_valid_out),
        .sample_count  (sample_count),
        .frame_count   (frame_count)
    );

    typedef struct {
        logic [63:0] d;
        logic [15:0] fc;
        int          cyc;
    } exp_t;

    exp_t        q[$];
    int          checks   = 0;
    int          failures = 0;
    int          cyc      = 0;
    logic [15:0] exp_fc   = 16'd0;
    logic [63:0] exp_avg;

    initial clock = 1'b0;
    always #5 clock = ~clock;

    always @(posedge clock) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%016h expected 0x%016h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Monitor: every pulse must match the head of the scoreboard, including its cycle.
    always @(negedge clock) begin
        if (data_valid_out !== 1'b0) begin
            if (q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_valid: data_valid_out=%b data_out=0x%016h with nothing expected (cycle %0d)",
                         data_valid_out, data_out, cyc);
            end else begin
                exp_t e;
                e = q.pop_front();
                chk("data_out", data_out, e.d);
                chk("frame_count", 64'(frame_count), 64'(e.fc));
                chk("pulse_cycle", 64'(cyc), 64'(e.cyc));
            end
        end
    end

    task automatic put(input logic en, input logic clr, input logic vld, input logic [63:0] d);
        enable     = en;
        clear      = clr;
        data_valid = vld;
        data_in    = d;
        @(posedge clock);
        #1;
    endtask

    task automatic smp(input logic [63:0] d);
        put(1'b1, 1'b0, 1'b1, d);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) put(1'b1, 1'b0, 1'b0, 64'd0);
    endtask

    // Call just before presenting the closing sample; its pulse is due one edge later.
    task automatic expect_out(input logic [63:0] d);
        exp_t e;
        exp_fc = exp_fc + 16'd1;
        e.d    = d;
        e.fc   = exp_fc;
        e.cyc  = cyc + 1;
        q.push_back(e);
    endtask

    initial begin
        reset      = 1'b1;
        enable     = 1'b0;
        clear      = 1'b0;
        data_valid = 1'b0;
        data_in    = 64'd0;
        repeat (2) @(posedge clock);
        #1;
        chk("reset_data_out", data_out, 64'd0);
        chk("reset_valid", 64'(data_valid_out), 64'd0);
        chk("reset_sample_count", 64'(sample_count), 64'd0);
        chk("reset_frame_count", 64'(frame_count), 64'd0);
        reset = 1'b0;
        idle(2);

        // T1: 4,8,12,16 -> 10
        smp(64'd4); smp(64'd8); smp(64'd12);
        chk("t1_sample_count", 64'(sample_count), 64'd3);
        expect_out(64'd10);
        smp(64'd16);
        idle(2);

        // T2: -5,-5,-5,-6 -> floor(-5.25)=-6, rounded -5
`ifdef ACUMULADOR_REDONDEO_EN
        exp_avg = 64'(-5);
`else
        exp_avg = 64'(-6);
`endif
        smp(64'(-5)); smp(64'(-5)); smp(64'(-5));
        expect_out(exp_avg);
        smp(64'(-6));
        idle(2);

        // T3: two back-to-back frames of the largest positive value
        for (int f = 0; f < 2; f++) begin
            smp(64'h7FFF_FFFF_FFFF_FFFF);
            smp(64'h7FFF_FFFF_FFFF_FFFF);
            smp(64'h7FFF_FFFF_FFFF_FFFF);
            expect_out(64'h7FFF_FFFF_FFFF_FFFF);
            smp(64'h7FFF_FFFF_FFFF_FFFF);
        end
        idle(3);
        chk("t3_data_out_hold", data_out, 64'h7FFF_FFFF_FFFF_FFFF);

        // T4: hold with enable=0 while valid data 100 is offered; sum 10 -> 2 (rounded 3)
`ifdef ACUMULADOR_REDONDEO_EN
        exp_avg = 64'd3;
`else
        exp_avg = 64'd2;
`endif
        smp(64'd1); smp(64'd2);
        for (int i = 0; i < 5; i++) begin
            put(1'b0, 1'b0, 1'b1, 64'd100);
            chk("t4_hold_sample_count", 64'(sample_count), 64'd2);
        end
        smp(64'd3);
        expect_out(exp_avg);
        smp(64'd4);
        idle(2);

        // T5: clear discards 1,2,3 and a coincident 50; then 4,4,4,4 -> 4
        smp(64'd1); smp(64'd2); smp(64'd3);
        put(1'b1, 1'b1, 1'b1, 64'd50);
        chk("t5_clear_sample_count", 64'(sample_count), 64'd0);
        chk("t5_clear_keeps_data_out", data_out, exp_avg);
        chk("t5_clear_keeps_frame_count", 64'(frame_count), 64'd5);
        smp(64'd4); smp(64'd4); smp(64'd4);
        expect_out(64'd4);
        smp(64'd4);
        idle(2);

        // clear while disabled is ignored: partial frame of one sample survives
        smp(64'd1);
        put(1'b0, 1'b1, 1'b1, 64'd9);
        chk("clear_ignored_sample_count", 64'(sample_count), 64'd1);
        smp(64'd1); smp(64'd1);
        expect_out(64'd1);
        smp(64'd1);
        idle(2);

        // T6: reset mid-frame zeroes everything at once, no output for that frame
        smp(64'd7); smp(64'd7); smp(64'd7);
        reset = 1'b1;
        #1;
        chk("t6_reset_data_out", data_out, 64'd0);
        chk("t6_reset_valid", 64'(data_valid_out), 64'd0);
        chk("t6_reset_sample_count", 64'(sample_count), 64'd0);
        chk("t6_reset_frame_count", 64'(frame_count), 64'd0);
        exp_fc = 16'd0;
        @(posedge clock);
        #1;
        reset = 1'b0;
        smp(64'd1); smp(64'd1); smp(64'd1);
        expect_out(64'd1);
        smp(64'd1);
        idle(4);

        chk("scoreboard_drained", 64'(q.size()), 64'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
